// File: rtl/ro_pair_eval_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : ro_pair_eval_ctrl
// Description : RO-PUF pair sequencer. For each pair it clears the counters,
//               runs a timed window, waits to settle, then compares the counts.
// Revision    : 1.0 - initial release
// ============================================================================
module ro_pair_eval_ctrl #(
    parameter int CNT_W     = 32,
    parameter int WIN_W     = 16,
    parameter int RESP_BITS = 8,
    parameter int SETTLE    = 4,
    parameter int SEL_W     = $clog2(RESP_BITS)
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    input  logic [WIN_W-1:0]     window_len,
    input  logic [CNT_W-1:0]     count_a,
    input  logic [CNT_W-1:0]     count_b,
    output logic [SEL_W-1:0]     sel,
    output logic                 cnt_clr,
    output logic                 cnt_en,
    output logic                 busy,
    output logic                 done,
    output logic [RESP_BITS-1:0] response,
    output logic                 tie
);

    localparam int C_SET_W = $clog2(SETTLE + 1);
    localparam int C_TMR_W = (WIN_W > C_SET_W) ? WIN_W : C_SET_W;
    localparam logic [C_TMR_W-1:0] C_SETTLE_LD = C_TMR_W'(SETTLE - 1);
    localparam logic [SEL_W-1:0]   C_SEL_LAST  = SEL_W'(RESP_BITS - 1);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_CLEAR   = 3'd1,
        S_RUN     = 3'd2,
        S_SETTLE  = 3'd3,
        S_COMPARE = 3'd4,
        S_DONE    = 3'd5
    } state_t;

    state_t                 state_q;
    logic [WIN_W-1:0]       win_q;
    logic [C_TMR_W-1:0]     timer_q;
    logic [SEL_W-1:0]       sel_q;
    logic                   cnt_clr_q;
    logic                   cnt_en_q;
    logic                   busy_q;
    logic                   done_q;
    logic [RESP_BITS-1:0]   resp_q;
    logic                   tie_q;

    // Outputs are registered alongside the state they belong to, so each one
    // is asserted in exactly the same cycle as its state.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= S_IDLE;
            win_q     <= '0;
            timer_q   <= '0;
            sel_q     <= '0;
            cnt_clr_q <= 1'b0;
            cnt_en_q  <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            resp_q    <= '0;
            tie_q     <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        win_q     <= (window_len == '0) ? WIN_W'(1) : window_len;
                        resp_q    <= '0;
                        tie_q     <= 1'b0;
                        sel_q     <= '0;
                        cnt_clr_q <= 1'b1;
                        busy_q    <= 1'b1;
                        state_q   <= S_CLEAR;
                    end
                end
                S_CLEAR: begin
                    cnt_clr_q <= 1'b0;
                    cnt_en_q  <= 1'b1;
                    timer_q   <= C_TMR_W'(win_q - WIN_W'(1));
                    state_q   <= S_RUN;
                end
                S_RUN: begin
                    if (timer_q == '0) begin
                        cnt_en_q <= 1'b0;
                        timer_q  <= C_SETTLE_LD;
                        state_q  <= S_SETTLE;
                    end else begin
                        timer_q  <= timer_q - C_TMR_W'(1);
                    end
                end
                S_SETTLE: begin
                    if (timer_q == '0) begin
                        state_q <= S_COMPARE;
                    end else begin
                        timer_q <= timer_q - C_TMR_W'(1);
                    end
                end
                S_COMPARE: begin
                    resp_q[sel_q] <= (count_a > count_b);
                    if (count_a == count_b) begin
                        tie_q <= 1'b1;
                    end
                    if (sel_q == C_SEL_LAST) begin
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        state_q <= S_DONE;
                    end else begin
                        sel_q     <= sel_q + SEL_W'(1);
                        cnt_clr_q <= 1'b1;
                        state_q   <= S_CLEAR;
                    end
                end
                S_DONE: begin
                    done_q  <= 1'b0;
                    state_q <= S_IDLE;
                end
                default: begin
                    cnt_clr_q <= 1'b0;
                    cnt_en_q  <= 1'b0;
                    busy_q    <= 1'b0;
                    done_q    <= 1'b0;
                    state_q   <= S_IDLE;
                end
            endcase
        end
    end

    assign sel      = sel_q;
    assign cnt_clr  = cnt_clr_q;
    assign cnt_en   = cnt_en_q;
    assign busy     = busy_q;
    assign done     = done_q;
    assign response = resp_q;
    assign tie      = tie_q;

endmodule
`default_nettype wire

// File: tb/tb_ro_pair_eval_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_ro_pair_eval_ctrl
// Description : Randomised bench for ro_pair_eval_ctrl with a timeline model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ro_pair_eval_ctrl;

    localparam int C_CW = 32;
    localparam int C_WW = 16;
    localparam int C_RB = 8;
    localparam int C_ST = 4;
    localparam int C_SW = 3;

    logic            clk = 1'b0;
    logic            reset = 1'b0;
    logic            start = 1'b0;
    logic [C_WW-1:0] window_len = '0;
    logic [C_CW-1:0] count_a;
    logic [C_CW-1:0] count_b;
    logic [C_SW-1:0] sel;
    logic            cnt_clr;
    logic            cnt_en;
    logic            busy;
    logic            done;
    logic [C_RB-1:0] response;
    logic            tie;

    logic [C_CW-1:0] ca [C_RB];
    logic [C_CW-1:0] cb [C_RB];

    int checks = 0;
    int errors = 0;

    // The counter pair seen by the DUT is whichever pair it currently selects.
    assign count_a = ca[sel];
    assign count_b = cb[sel];

    always #5 clk = ~clk;

    ro_pair_eval_ctrl #(
        .CNT_W(C_CW), .WIN_W(C_WW), .RESP_BITS(C_RB), .SETTLE(C_ST), .SEL_W(C_SW)
    ) dut (
        .clk(clk), .reset(reset), .start(start), .window_len(window_len),
        .count_a(count_a), .count_b(count_b), .sel(sel), .cnt_clr(cnt_clr),
        .cnt_en(cnt_en), .busy(busy), .done(done), .response(response), .tie(tie)
    );

    task automatic test_reset();
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            start = 1'($urandom);
            window_len = C_WW'($urandom);
        end
        @(negedge clk);
        checks++;
        if ({sel, cnt_clr, cnt_en, busy, done, response, tie} !== '0) begin
            errors++;
            $display("FAIL reset_outputs: got sel=%0d clr=%b en=%b busy=%b done=%b resp=%h tie=%b, want all 0",
                     sel, cnt_clr, cnt_en, busy, done, response, tie);
        end
        start = 1'b0;
        reset = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            checks++;
            if ({busy, cnt_clr, cnt_en, done} !== 4'b0) begin
                errors++;
                $display("FAIL idle_after_reset: got busy=%b clr=%b en=%b done=%b, want 0",
                         busy, cnt_clr, cnt_en, done);
            end
        end
    endtask

    // Runs one full measurement and checks it against the spec timeline:
    // per-bit period P = win+SETTLE+2, CLEAR at offset 0, enable at 1..win,
    // done one cycle after the last bit.
    task automatic do_run(input int w, input bit perturb, input bit start_in_done, input string name);
        int weff, p, total, done_exp, b, o, done_at, done_pulses;
        int sel_bad, busy_bad, misplaced;
        int en_cnt [C_RB];
        int clr_cnt [C_RB];
        logic [C_RB-1:0] exp_resp;
        bit exp_tie;
        weff = (w == 0) ? 1 : w;
        p = weff + C_ST + 2;
        total = C_RB * p;
        done_exp = total + 1;
        done_at = -1; done_pulses = 0; sel_bad = 0; busy_bad = 0; misplaced = 0;
        exp_resp = '0; exp_tie = 1'b0;
        for (int i = 0; i < C_RB; i++) begin
            en_cnt[i] = 0; clr_cnt[i] = 0;
            if (ca[i] > cb[i]) exp_resp[i] = 1'b1;
            if (ca[i] == cb[i]) exp_tie = 1'b1;
        end
        @(negedge clk);
        start = 1'b1;
        window_len = C_WW'(w);
        @(posedge clk);
        for (int c = 1; c <= done_exp + 1; c++) begin
            @(negedge clk);
            if (c < done_exp && perturb) begin
                start = 1'($urandom);
                window_len = C_WW'($urandom);
            end else if (c == done_exp) begin
                start = start_in_done;
            end else begin
                start = 1'b0;
            end
            if (c == 1) begin
                checks++;
                if (response !== '0 || tie !== 1'b0) begin
                    errors++;
                    $display("FAIL %s start_clears: got resp=%h tie=%b, want 00 0", name, response, tie);
                end
            end
            if (c <= total) begin
                b = (c - 1) / p;
                o = (c - 1) % p;
                if (sel !== C_SW'(b)) sel_bad++;
                if (busy !== 1'b1) busy_bad++;
                if (cnt_en === 1'b1) begin
                    en_cnt[b]++;
                    if (o < 1 || o > weff) misplaced++;
                end
                if (cnt_clr === 1'b1) begin
                    clr_cnt[b]++;
                    if (o != 0) misplaced++;
                end
            end else begin
                if (busy !== 1'b0) busy_bad++;
                if (cnt_en !== 1'b0 || cnt_clr !== 1'b0) misplaced++;
            end
            if (done === 1'b1) begin
                done_pulses++;
                if (done_at < 0) done_at = c;
            end
            if (c == done_exp) begin
                checks++;
                if (response !== exp_resp || tie !== exp_tie) begin
                    errors++;
                    $display("FAIL %s result: got resp=%h tie=%b, want resp=%h tie=%b",
                             name, response, tie, exp_resp, exp_tie);
                end
            end
        end
        checks++;
        if (done_at != done_exp) begin
            errors++;
            $display("FAIL %s done_cycle: got t0+%0d, want t0+%0d", name, done_at, done_exp);
        end
        checks++;
        if (done_pulses != 1) begin
            errors++;
            $display("FAIL %s done_pulses: got %0d, want 1", name, done_pulses);
        end
        checks++;
        if (sel_bad != 0 || busy_bad != 0 || misplaced != 0) begin
            errors++;
            $display("FAIL %s timeline: got sel_bad=%0d busy_bad=%0d misplaced=%0d, want 0 0 0",
                     name, sel_bad, busy_bad, misplaced);
        end
        for (int i = 0; i < C_RB; i++) begin
            checks++;
            if (en_cnt[i] != weff || clr_cnt[i] != 1) begin
                errors++;
                $display("FAIL %s bit%0d_window: got en=%0d clr=%0d, want en=%0d clr=1",
                         name, i, en_cnt[i], clr_cnt[i], weff);
            end
        end
        for (int i = 0; i < 3; i++) @(negedge clk);
        checks++;
        if (busy !== 1'b0 || response !== exp_resp || tie !== exp_tie) begin
            errors++;
            $display("FAIL %s hold_after_done: got busy=%b resp=%h tie=%b, want 0 %h %b",
                     name, busy, response, tie, exp_resp, exp_tie);
        end
    endtask

    task automatic test_basic();
        for (int i = 0; i < C_RB; i++) begin
            ca[i] = C_CW'(100 + i);
            cb[i] = C_CW'(50);
        end
        do_run(10, 1'b0, 1'b0, "basic");
        checks++;
        if (response !== 8'hFF || tie !== 1'b0) begin
            errors++;
            $display("FAIL basic_const: got resp=%h tie=%b, want ff 0", response, tie);
        end
    endtask

    task automatic test_mixed_tie();
        for (int i = 0; i < C_RB; i++) begin
            ca[i] = (i % 2 == 0) ? C_CW'(200) : C_CW'(10);
            cb[i] = C_CW'(100);
        end
        ca[3] = C_CW'(77);
        cb[3] = C_CW'(77);
        do_run(5, 1'b0, 1'b1, "mixed");
        checks++;
        if (response !== 8'h55 || tie !== 1'b1) begin
            errors++;
            $display("FAIL mixed_const: got resp=%h tie=%b, want 55 1", response, tie);
        end
    endtask

    task automatic test_window_zero();
        for (int i = 0; i < C_RB; i++) begin
            ca[i] = C_CW'($urandom);
            cb[i] = C_CW'($urandom);
        end
        do_run(0, 1'b0, 1'b0, "win0");
    endtask

    task automatic test_random_back_to_back();
        for (int r = 0; r < 4; r++) begin
            for (int i = 0; i < C_RB; i++) begin
                ca[i] = C_CW'($urandom);
                cb[i] = ($urandom_range(0, 3) == 0) ? ca[i] : C_CW'($urandom);
            end
            do_run(int'($urandom_range(0, 12)), 1'b1, 1'($urandom), "random");
        end
    endtask

    task automatic test_reset_mid_run();
        bit found;
        int done_seen;
        found = 1'b0;
        done_seen = 0;
        for (int i = 0; i < C_RB; i++) begin
            ca[i] = C_CW'($urandom);
            cb[i] = C_CW'($urandom);
        end
        @(negedge clk);
        start = 1'b1;
        window_len = C_WW'(3);
        @(negedge clk);
        start = 1'b0;
        for (int i = 0; i < 200 && !found; i++) begin
            @(negedge clk);
            if (sel === C_SW'(5) && cnt_en === 1'b1) found = 1'b1;
        end
        checks++;
        if (!found) begin
            errors++;
            $display("FAIL midrun_reach_sel5: got not found, want RUN of sel 5 within 200 cycles");
        end
        #2 reset = 1'b0;
        #1;
        checks++;
        if ({sel, cnt_clr, cnt_en, busy, done, response, tie} !== '0) begin
            errors++;
            $display("FAIL midrun_async_clear: got sel=%0d clr=%b en=%b busy=%b done=%b resp=%h tie=%b, want all 0",
                     sel, cnt_clr, cnt_en, busy, done, response, tie);
        end
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            if (done === 1'b1) done_seen++;
        end
        reset = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if (done === 1'b1 || busy !== 1'b0) done_seen++;
        end
        checks++;
        if (done_seen != 0) begin
            errors++;
            $display("FAIL midrun_no_done: got %0d done/busy cycles after reset, want 0", done_seen);
        end
        do_run(4, 1'b0, 1'b0, "after_reset");
    endtask

    initial begin
        for (int i = 0; i < C_RB; i++) begin
            ca[i] = '0;
            cb[i] = '0;
        end
        test_reset();
        test_basic();
        test_mixed_tie();
        test_window_zero();
        test_random_back_to_back();
        test_reset_mid_run();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/ro_pair_eval_ctrl.md
# ro_pair_eval_ctrl

Measurement sequencer and comparator that sits directly downstream of the RO edge counters in the RO-PUF datapath. For each response bit it selects one ring-oscillator pair and clears its two counters, then enables them for a programmable window. After a settle interval it compares the two counts and shifts the result into an N-bit response register. It drives the counters' enable and clear and consumes their count outputs.

## Interface
- CNT_W, 32: width of each counter value input.
- WIN_W, 16: width of the measurement-window length input.
- RESP_BITS, 8: number of response bits (RO pairs) evaluated per run; must be ≥2.
- SETTLE, 4: idle cycles after the window closes before counts are sampled; must be ≥1.
- SEL_W, $clog2(RESP_BITS): width of the pair-select output.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- reset  input  1  asynchronous, active-low reset (0 = reset asserted).
- start  input  1  begin a run; sampled only in IDLE.
- window_len  input  WIN_W  enable-window length in clk cycles; latched on start.
- count_a  input  CNT_W  count from the selected pair's first counter.
- count_b  input  CNT_W  count from the selected pair's second counter.
- sel  output  SEL_W  index of the RO pair currently under evaluation.
- cnt_clr  output  1  clear pulse to the selected pair's counters.
- cnt_en  output  1  enable to the selected pair's counters.
- busy  output  1  high while a run is in progress.
- done  output  1  one-cycle pulse when the response is complete.
- response  output  RESP_BITS  assembled PUF response.
- tie  output  1  sticky: at least one pair compared equal this run.

## Operation
- States: IDLE, CLEAR, RUN, SETTLE, COMPARE, DONE.
- IDLE:
  - start=1 latches window_len into win_q, using 1 if window_len==0.
  - Clears response, tie and sel to 0, then goes to CLEAR.
  - start=0 remains in IDLE.
- CLEAR: cnt_clr=1 for exactly 1 cycle, then RUN.
- RUN: cnt_en=1 for exactly win_q cycles, timed by an internal down-counter, then SETTLE.
- SETTLE: cnt_en=0 for SETTLE cycles so the RO-clocked counters stop and stabilise, then COMPARE.
- COMPARE: 1 cycle.
  - Writes response[sel] <= (count_a > count_b), an unsigned CNT_W-bit compare.
  - If count_a==count_b, the bit is 0 and tie is set to 1.
  - If sel==RESP_BITS-1, go to DONE; otherwise sel increments and the FSM goes to CLEAR.
- DONE: done=1 for 1 cycle, then IDLE.
- sel is stable from CLEAR through COMPARE of each bit. It changes only on the COMPARE→CLEAR edge.
- busy=1 in CLEAR, RUN, SETTLE and COMPARE; busy=0 in IDLE and DONE.
- start is ignored in every state except IDLE, including DONE. window_len changes during a run have no effect.
- response and tie hold their values after DONE until the next accepted start.
- Counter wrap-around is not detected. A wrapped count compares as its raw CNT_W-bit value.

## Timing
- reset=0 asynchronously forces the following:
  - state=IDLE, sel=0, cnt_clr=0, cnt_en=0.
  - busy=0, done=0, response=0, tie=0.
  - Internal counters = 0.
- Reset mid-run aborts immediately. No done is produced. The first cycle after reset release is IDLE.
- Per-bit duration is 1 + win_q + SETTLE + 1 cycles.
- start sampled at edge t0:
  - CLEAR occupies cycle t0+1.
  - cnt_en is high for cycles t0+2 … t0+1+win_q.
  - The first COMPARE is at cycle t0+2+win_q+SETTLE.
- done is high at cycle t0 + RESP_BITS·(win_q+SETTLE+2) + 1.
- A new start is accepted at the earliest in the cycle after done.
- All outputs are registered or decoded from the state register. There are no combinational paths from inputs to outputs.

## Test plan
- Reset check: hold reset=0, toggle start and clk → all outputs 0. Release reset, no start → stays IDLE with busy=0.
- Basic run: RESP_BITS=8, SETTLE=4, window_len=10. Drive count_a=100+sel, count_b=50 → done at t0+129; response=8'hFF; tie=0; cnt_en high exactly 10 cycles per bit.
- Mixed and tie: count_a>count_b for even sel, < for odd sel, equal for sel=3 → response=8'h55; tie=1.
- window_len=0 → behaves as window 1: exactly 1 cnt_en cycle per bit; done at t0+57.
- Start while busy and start in DONE are ignored. Changing window_len mid-run does not alter window length. response holds after done until the next start, which clears it to 0.
- Assert reset during RUN of sel=5 → outputs clear immediately, no done. A fresh start then completes a full 8-bit run normally.
